// File: rtl/alu_mult_seq.sv
// ALU operand-issue/result-collection stage: single-cycle logic/arith ops resolved
// locally, MUL sequenced through an external mult32 with a fixed iteration count.
module alu_mult_seq #(
  parameter int unsigned MULT_CYCLES = 66
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_rst,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_hi
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(MULT_CYCLES + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MRST  = 2'd1,
    S_MWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d, hi_q, hi_d;
  logic                out_valid_q, out_valid_d;
  logic                mul_rst_q, mul_rst_d;
  logic [DATA_W-1:0]   alu_c;

  // Single-cycle result computed straight from the request being accepted
  always_comb begin
    alu_c = '0;
    case (in_op)
      OP_AND:  alu_c = in_a & in_b;
      OP_OR:   alu_c = in_a | in_b;
      OP_XOR:  alu_c = in_a ^ in_b;
      OP_ADD:  alu_c = in_a + in_b;
      OP_SUB:  alu_c = in_a - in_b;
      OP_SLT:  alu_c = ($signed(in_a) < $signed(in_b)) ? DATA_W'(1) : '0;
      OP_NOR:  alu_c = ~(in_a | in_b);
      default: alu_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          a_d  = in_a;
          b_d  = in_b;
          if (in_op == OP_MUL) begin
            state_d = S_MRST;
          end else begin
            res_d   = alu_c;
            hi_d    = '0;
            state_d = S_RESP;
          end
        end
      end
      S_MRST: begin
        cnt_d   = '0;
        state_d = (op_q == OP_MUL) ? S_MWAIT : S_IDLE;
      end
      S_MWAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MULT_CYCLES - 1)) begin
          res_d   = mul_product[31:0];
          hi_d    = mul_product[63:32];
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_RESP);
    // Multiplier is only released while it is iterating
    mul_rst_d   = (state_d != S_MWAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      mul_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      mul_rst_q   <= mul_rst_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign mul_rst    = mul_rst_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_hi     = hi_q;

endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Operand-issue and result-collection stage that sits directly in front of the `mult32` sequential multiplier in the ALU. It accepts one ALU request at a time over a valid/ready handshake and resolves single-cycle logic and arithmetic ops locally. For MUL it drives `mult32` by holding operands stable and sequencing its reset, waits a fixed iteration count, then captures the 64-bit product. Results leave over a valid/ready output handshake.

## Interface
- `MULT_CYCLES`, default 66: number of cycles `mult32` needs after its reset deasserts until its product output is final.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `in_op` in 3: opcode. 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT (signed), 110 NOR, 111 MUL.
- `in_a`, `in_b` in 32 each: operands.
- `mul_rst` out 1: drives `mult32` rst.
- `mul_a`, `mul_b` out 32 each: drive `mult32` a and b.
- `mul_product` in 64: `mult32` result.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result.
- `out_result` out 32: low word of the result.
- `out_hi` out 32: upper product word for MUL, 0 otherwise.

## Operation
- States: IDLE, MRST, MWAIT, RESP.
- Accept: an accept occurs on the edge where `in_valid && in_ready`. `in_ready` = (state==IDLE), combinational. `in_op`, `in_a` and `in_b` are registered on accept.
- IDLE, accepted op ≠ MUL:
  - Compute on the accept edge and register into `out_result`. `out_hi` = 0.
  - Next state RESP.
- IDLE, accepted MUL: next state MRST.
- MRST: `mul_rst`=1 for exactly one cycle, then MWAIT. The cycle counter clears to 0.
- MWAIT:
  - `mul_rst`=0. The counter increments every cycle.
  - On the edge where counter==MULT_CYCLES-1, register `mul_product[31:0]` into `out_result` and `mul_product[63:32]` into `out_hi`, then go to RESP.
- RESP: `out_valid`=1. On the edge where `out_ready`=1, go to IDLE. There is no bypass: `in_ready` stays 0 in RESP.
- `mul_rst`=1 in every state except MWAIT, so the multiplier stays held in reset while unused.
- `mul_a`/`mul_b` come from the operand registers and are stable from MRST through the end of MWAIT.
- Arithmetic:
  - ADD/SUB wrap modulo 2^32, with no carry or overflow output.
  - SLT gives 32'd1 if $signed(a)<$signed(b), else 0.
  - NOR = ~(a|b).
  - MUL is unsigned 32x32→64.
- Boundaries:
  - `in_valid` while busy is ignored; the request must be held by its source.
  - `out_ready` low in RESP: `out_valid`, `out_result` and `out_hi` hold unchanged.
  - `rst` in any state, including mid-MWAIT: next edge goes to IDLE with `out_valid`=0 and `mul_rst`=1. Any pending result is discarded and no response is produced.
  - MUL with a or b = 0 still takes the full MULT_CYCLES.

## Timing
- Reset values after a `rst` edge:
  - state IDLE, `in_ready`=1, `out_valid`=0
  - `out_result`=0, `out_hi`=0
  - `mul_rst`=1, `mul_a`=0, `mul_b`=0, counter 0
- Non-MUL: accept at edge E, `out_valid`=1 from E+1.
- MUL: accept at edge E.
  - `mul_rst`=1 during cycle E→E+1.
  - MWAIT spans edges E+1..E+1+MULT_CYCLES.
  - `out_valid`=1 from E+1+MULT_CYCLES (67 cycles at default).
- Handshake completes on the edge with `out_valid && out_ready`. `in_ready` rises one cycle later, so the minimum spacing between back-to-back non-MUL ops is 2 cycles.
- `out_valid` never drops without a completed handshake or `rst`.

## Test plan
- Reset with `in_valid`=0 → `in_ready`=1, `out_valid`=0, `out_result`=0, `out_hi`=0, `mul_rst`=1.
- MUL a=12, b=6 with real `mult32` and `out_ready`=1 → `mul_rst` low for exactly 66 cycles, `out_valid` at accept+67, `out_result`=72, `out_hi`=0; `in_ready`=1 one cycle after the handshake.
- MUL a=32'hFFFFFFFF, b=32'hFFFFFFFF → `out_hi`=32'hFFFFFFFE, `out_result`=32'h00000001.
- Back-to-back ADD 32'hFFFFFFFF+1 then SLT a=-1, b=1 → first result 0, second 1. Each `out_valid` arrives 1 cycle after its accept. `in_ready`=0 while in RESP.
- Backpressure: SUB 5-7 with `out_ready`=0 for 10 cycles → `out_result`=32'hFFFFFFFE held stable with `out_valid`=1; completes on the first `out_ready`=1 edge.
- `rst` pulsed for one cycle 20 cycles into a MUL → next cycle IDLE, `mul_rst`=1, `out_valid` stays 0, no result emitted. A following AND of 32'hF0F0 & 32'h0FF0 returns 32'h00F0.
